// File: rtl/pfb_pkg.sv
// Shared definitions for the channelizer polyphase filterbank: accumulator
// width, default output geometry and the round/saturate helpers.
package pfb_pkg;

    localparam int P_W            = 48;
    localparam int SHIFT_DEF      = 15;
    localparam int OUT_W_DEF      = 16;
    localparam int PHASE_W_DEF    = 6;
    localparam int FIFO_DEPTH_DEF = 8;

    // Add half an output LSB, one bit wider than the accumulator so it never wraps.
    function automatic logic signed [P_W:0] round_add(input logic signed [P_W-1:0] p,
                                                      input int shift);
        logic signed [P_W:0] half;
        half = {{P_W{1'b0}}, 1'b1} << (shift - 1);
        return $signed({p[P_W-1], p}) + half;
    endfunction

    // Shift the pre-rounded accumulator down and clamp it to out_w signed bits.
    // Returns {sat_flag, value}; value is the clamped result in its low out_w bits.
    function automatic logic [32:0] sat_round(input logic signed [P_W:0] r,
                                              input int shift, input int out_w);
        logic signed [P_W:0] q;
        logic signed [P_W:0] one;
        logic signed [P_W:0] maxv;
        logic signed [P_W:0] minv;
        logic [32:0]         res;
        one  = {{P_W{1'b0}}, 1'b1};
        q    = r >>> shift;
        maxv = (one << (out_w - 1)) - one;
        minv = '0 - (one << (out_w - 1));
        if (q > maxv)
            res = {1'b1, maxv[31:0]};
        else if (q < minv)
            res = {1'b1, minv[31:0]};
        else
            res = {1'b0, q[31:0]};
        return res;
    endfunction

endpackage

// File: rtl/pfb_mac_tail_fifo.sv
// Small synchronous circular-buffer FIFO holding {phase, sample} results.
// Head is shown combinationally; the parent never pushes when full.
module pfb_tail_fifo #(
    parameter int W     = 22,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/pfb_mac_tail.sv
// Terminal stage of the PFB MAC cascade: round, shift, saturate, tag with
// branch index, buffer and present on AXI-Stream. ce_out freezes the whole
// MAC chain whenever the FIFO could not absorb everything still in flight.
module pfb_mac_tail
    import pfb_pkg::*;
#(
    parameter int SHIFT      = SHIFT_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic [P_W-1:0]     s_p,
    input  logic               s_valid,
    input  logic [PHASE_W-1:0] s_phase,
    output logic               ce_out,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic [PHASE_W-1:0] m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               overflow
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = OUT_W + PHASE_W;

    logic                      run;
    logic                      accept;
    logic                      v1, v2;
    logic signed [P_W:0]       r1;
    logic [PHASE_W-1:0]        ph1, ph2;
    logic [OUT_W-1:0]          d2;
    logic [32:0]               sr;
    logic [CW-1:0]             cnt;
    logic [CW:0]               occ;
    logic [DW-1:0]             head;
    logic                      pop;

    assign accept = s_valid && ce_out;

    // Reserve a FIFO slot for everything in the two pipeline stages; only
    // registers feed this so the enable fanning out to the taps is clean.
    assign occ    = {1'b0, cnt} + (CW+1)'(v1) + (CW+1)'(v2);
    assign ce_out = run && (occ < (CW+1)'(FIFO_DEPTH));

    // Holds ce_out low during reset and releases it one cycle after.
    always_ff @(posedge clk) begin
        if (sync_reset) run <= 1'b0;
        else            run <= 1'b1;
    end

    // Stage 1: add rounding constant.
    always_ff @(posedge clk) begin
        if (sync_reset) v1 <= 1'b0;
        else            v1 <= accept;
        r1  <= round_add($signed(s_p), SHIFT);
        ph1 <= s_phase;
    end

    // Shift and clamp the stage 1 value.
    always_comb begin
        sr = sat_round(r1, SHIFT, OUT_W);
    end

    // Stage 2: register clamped sample, accumulate sticky overflow.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            v2       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1 && sr[32])
                overflow <= 1'b1;
        end
        d2  <= sr[OUT_W-1:0];
        ph2 <= ph1;
    end

    pfb_tail_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (v2),
        .din        ({ph2, d2}),
        .pop        (pop),
        .head       (head),
        .count      (cnt)
    );

    assign m_axis_tvalid = (cnt != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    // Force zeros when empty so stale FIFO storage never shows on the bus.
    assign m_axis_tdata  = m_axis_tvalid ? head[OUT_W-1:0]  : '0;
    assign m_axis_tuser  = m_axis_tvalid ? head[DW-1:OUT_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (&head[DW-1:OUT_W]);

endmodule

// File: tb/tb_pfb_mac_tail.sv
// Directed bench for pfb_mac_tail (SHIFT=15, OUT_W=16, PHASE_W=6, depth 8).
module tb_pfb_mac_tail;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic [47:0] s_p;
    logic        s_valid;
    logic [5:0]  s_phase;
    logic        ce_out;
    logic [15:0] tdata;
    logic [5:0]  tuser;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  ph;
    } exp_t;

    exp_t sb[$];
    int   maxocc = 0;

    pfb_mac_tail dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .s_p           (s_p),
        .s_valid       (s_valid),
        .s_phase       (s_phase),
        .ce_out        (ce_out),
        .m_axis_tdata  (tdata),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: round half up, shift by 15, clamp to int16.
    function automatic logic [15:0] model(input logic [47:0] p);
        longint v;
        v = longint'($signed(p));
        v = (v + 64'sd16384) >>> 15;
        if (v > 64'sd32767)       return 16'h7FFF;
        else if (v < -64'sd32768) return 16'h8000;
        else                      return v[15:0];
    endfunction

    // One clock with scoreboard bookkeeping for this cycle's handshakes.
    task automatic step();
        exp_t e;
        logic popped, acc;
        popped = tvalid && tready;
        acc    = s_valid && ce_out;
        if (popped) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_out", {tdata, tuser, tlast}, {e.d, e.ph, (e.ph == 6'd63)});
            end
        end
        if (acc) begin
            e.d  = model(s_p);
            e.ph = s_phase;
            sb.push_back(e);
        end
        if (sb.size() > maxocc) maxocc = sb.size();
        tick();
    endtask

    task automatic drain(input string tag);
        s_valid = 1'b0;
        tready  = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) step();
        chk(tag, sb.size(), 0);
        chk({tag, "_tvalid"}, tvalid, 0);
    endtask

    // Single sample, hand-computed result, exact 3-cycle latency.
    task automatic send_one(input string tag, input logic [47:0] p, input logic [5:0] ph,
                            input logic [15:0] expd);
        chk({tag, "_ce"}, ce_out, 1);
        s_p = p; s_phase = ph; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk({tag, "_lat1"}, tvalid, 0);
        tick();
        chk({tag, "_lat2"}, tvalid, 0);
        tick();
        chk({tag, "_lat3"}, tvalid, 1);
        chk({tag, "_data"}, tdata, expd);
        chk({tag, "_user"}, tuser, ph);
        tick();
        chk({tag, "_gone"}, tvalid, 0);
    endtask

    initial begin
        int     nacc;
        int     nseen;
        longint lv;
        logic [5:0] ph;

        sync_reset = 1'b1; s_valid = 1'b0; s_p = '0; s_phase = '0; tready = 1'b1;
        tick(); tick();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tuser", tuser, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_ce", ce_out, 0);
        chk("rst_ovf", overflow, 0);
        sync_reset = 1'b0;
        tick();
        chk("rst_ce_rise", ce_out, 1);

        // Rounding boundaries.
        send_one("rnd_half_up", 48'h000000004000, 6'd1, 16'h0001);
        send_one("rnd_below",   48'h000000003FFF, 6'd2, 16'h0000);
        send_one("rnd_neg_tie", 48'hFFFFFFFFC000, 6'd3, 16'h0000);
        send_one("rnd_neg",     48'hFFFFFFFFBFFF, 6'd4, 16'hFFFF);
        chk("ovf_clear", overflow, 0);

        // Saturation.
        send_one("sat_pos", 48'h000080000000, 6'd5, 16'h7FFF);
        chk("ovf_set", overflow, 1);
        send_one("sat_neg", 48'hFFFF80000000, 6'd6, 16'h8000);
        tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            lv = longint'(i - 50) * 64'sd32768;
            s_p = lv[47:0]; s_phase = 6'(i); s_valid = 1'b1;
            step();
            chk("ovf_sticky", overflow, 1);
        end
        drain("drain_inrange");

        // Backpressure: exactly depth samples accepted.
        tready = 1'b0; s_valid = 1'b1; nacc = 0; ph = '0;
        for (int i = 0; i < 20; i++) begin
            s_phase = ph; s_p = 48'(ph) << 15;
            if (ce_out) begin nacc++; ph++; end
            step();
        end
        chk("bp_accepted", nacc, 8);
        chk("bp_ce_low", ce_out, 0);
        chk("bp_tvalid", tvalid, 1);
        s_valid = 1'b0; tready = 1'b1;
        step();
        chk("bp_ce_back", ce_out, 1);
        for (int i = 0; i < 7; i++) begin
            chk("bp_no_gap", tvalid, 1);
            step();
        end
        chk("bp_empty", sb.size(), 0);
        chk("bp_tvalid_end", tvalid, 0);

        // Frame tagging: full frame, tlast on phase 63 only (scoreboard).
        for (int i = 0; i < 64; i++) begin
            s_phase = 6'(i); s_p = 48'(i * 1000); s_valid = 1'b1;
            step();
        end
        drain("drain_frame");

        // Random traffic against the model.
        ph = '0;
        for (int i = 0; i < 10000; i++) begin
            lv = longint'(int'($urandom)) >>> $urandom_range(0, 16);
            s_p = lv[47:0]; s_phase = ph; ph++;
            s_valid = ($urandom_range(0, 3) != 0);
            tready  = $urandom_range(0, 1) == 1;
            step();
        end
        drain("drain_random");
        chk("max_occupancy_le8", maxocc <= 8, 1);

        // Reset mid-stream with 5 samples buffered.
        send_one("pre_rst_sat", 48'h7FFFFFFFFFFF, 6'd9, 16'h7FFF);
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_phase = 6'(i); s_p = 48'(i) << 15; s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid_buffered", tvalid, 1);
        chk("mid_ovf_before", overflow, 1);
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        sb.delete();
        chk("mid_tvalid", tvalid, 0);
        chk("mid_ce", ce_out, 0);
        chk("mid_ovf", overflow, 0);
        tick();
        chk("mid_ce_rise", ce_out, 1);
        tready = 1'b1; nseen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tvalid) nseen++;
            tick();
        end
        chk("mid_no_stale", nseen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pfb_mac_tail.md
Name: pfb_mac_tail

Overview:
- Terminal stage of the channelizer polyphase-filterbank MAC cascade.
- Receives the 48-bit accumulated P output of the last DSP48 tap, rounds and shifts it, saturates it to the output width, and tags it with its polyphase branch index.
- Buffers results in a small FIFO and presents them on an AXI-Stream master.
- Drives the clock enable back to the MAC chain, so downstream backpressure stalls the whole cascade without losing samples.

Parameters:
- SHIFT, 15, right-shift applied to the accumulator (coefficient fraction bits); 1..40.
- OUT_W, 16, signed output sample width; 2..32.
- PHASE_W, 6, width of the branch index; number of branches = 2^PHASE_W.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥4.

Ports:
- clk  in  1  clock.
- sync_reset  in  1  synchronous reset, active-high.
- s_p  in  48  signed accumulator from the last MAC tap.
- s_valid  in  1  s_p is valid; already aligned to the DSP pipeline latency and gated by ce_out upstream.
- s_phase  in  PHASE_W  branch index of s_p.
- ce_out  out  1  clock enable to every MAC tap and to the upstream valid/phase delay line.
- m_axis_tdata  out  OUT_W  rounded, saturated sample.
- m_axis_tuser  out  PHASE_W  branch index.
- m_axis_tlast  out  1  high when tuser is all ones (last branch of the frame).
- m_axis_tvalid  out  1  AXI-S valid.
- m_axis_tready  in  1  AXI-S ready.
- overflow  out  1  sticky; set whenever saturation occurs; cleared only by reset.

Behaviour:
- Reset: single clock, clk. sync_reset is synchronous and active-high. While it is asserted:
  - all stage valids, the FIFO pointers and the FIFO count clear;
  - overflow clears;
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0;
  - ce_out = 0.
  - ce_out rises on the first cycle after reset deasserts.
  - Reset mid-stream discards all in-flight and buffered data, with no partial output.
- Accept condition: a sample is accepted iff s_valid && ce_out. When s_valid is high but ce_out is low, the sample is ignored; upstream holds it because its own pipeline is frozen.
- Stage 1 (registered): r1 = s_p + 2^(SHIFT-1), computed 49 bits wide and sign-extended, so there is no wrap. This is round-half-up (toward +inf on ties).
- Stage 2 (registered):
  - q = r1 >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1, the output is 2^(OUT_W-1)-1. If q < -2^(OUT_W-1), the output is -2^(OUT_W-1). Otherwise the output is q[OUT_W-1:0].
  - The saturation flag is ORed into overflow in this cycle.
  - Phase is carried in step with the data.
- Stage 2 valid writes into the FIFO the following cycle. Stages 1 and 2 are free-running and never stall.
- Latency: an accepted sample with the FIFO empty and tready=1 appears on m_axis at cycle N+3 after acceptance at N.
- ce_out = (fifo_count + v1 + v2) < FIFO_DEPTH, where v1 and v2 are the stage 1 and stage 2 valid bits.
  - ce_out is computed from registers only, so it is glitch-free.
  - This guarantees every accepted sample has a reserved FIFO slot; the FIFO can never overflow.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop of the last entry with a simultaneous push keeps tvalid high.
- AXI-S output:
  - m_axis_tvalid = (count != 0).
  - tdata, tuser and tlast show the head entry.
  - Once tvalid is asserted, the data stays stable until tready.
- Ordering: strictly FIFO; none dropped, none duplicated.

Decomposition:
- Shared package pfb_pkg holds:
  - P_W = 48;
  - the rounding/saturation function sat_round(p, SHIFT, OUT_W), returning {sat_flag, value};
  - the output width defaults, shared with the channelizer top.
- One sub-module, pfb_tail_fifo: a synchronous FIFO of width OUT_W+PHASE_W, depth FIFO_DEPTH, exposing count, push, pop and head.

Test Plan:
- SHIFT=15, OUT_W=16:
  - s_p=0x000000004000 → tdata 0x0001;
  - s_p=0x000000003FFF → 0x0000;
  - s_p=0xFFFFFFFFC000 (-16384) → 0x0000;
  - s_p=0xFFFFFFFFBFFF → 0xFFFF.
  - Each result arrives 3 cycles after acceptance.
- Saturation:
  - s_p=2^31 → 0x7FFF and overflow rises;
  - s_p=-2^31 → 0x8000;
  - overflow stays 1 across 100 following in-range samples.
- Backpressure: hold tready=0 with s_valid continuously high and phases 0..63.
  - Exactly 8 samples are accepted, then ce_out stays low.
  - Raise tready: the samples emerge in order with no gaps or duplicates, and ce_out reasserts once occupancy is below 8.
- Frame tagging: stream phases 0..63 with tready=1 → tuser matches each sample, and tlast is high only on phase 63.
- Random tready (50%) with 10k random s_p → the output matches a scoreboard model exactly, and the FIFO never exceeds 8.
- Reset mid-stream:
  - Assert sync_reset for 1 cycle with 5 samples buffered → the next cycle shows tvalid=0, ce_out=0, overflow=0.
  - The cycle after, ce_out=1 and none of the old samples ever appear.
